// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot column drive, 2-FF row sync, frame debounce, optional decimal entry.
// Press events arrive DEBOUNCE_SCANS frames after the key first appears; no backpressure (pulses are fire-and-forget).
module keypad_scan_ctrl #(
  parameter int NUM_COLS       = 4,
  parameter int NUM_ROWS       = 4,
  parameter int SCAN_DIV       = 450000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int ENTRY_EN       = 1,
  parameter int DIGITS         = 2,
  localparam int IDX_W  = (NUM_ROWS * NUM_COLS > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1,
  localparam int ACC_W  = $clog2(10 ** DIGITS),
  localparam int DCNT_W = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_ROWS-1:0] filas,
  output logic [NUM_COLS-1:0] col,
  output logic [IDX_W-1:0]    key_idx,
  output logic [3:0]          key_legend,
  output logic                key_valid,
  output logic                key_held,
  output logic [ACC_W-1:0]    acc_value,
  output logic [DCNT_W-1:0]   digit_count,
  output logic                overflow,
  output logic [ACC_W-1:0]    entry_value,
  output logic                entry_valid
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CI_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam bit IS_4X4 = (NUM_COLS == 4) && (NUM_ROWS == 4);
  // Nibble i holds the legend of key index i (col*4+row); E='*', F='#'.
  localparam logic [63:0] LEGEND_TBL = 64'hDF0E_C987_B654_A321;

  generate
    if (ENTRY_EN != 0 && !IS_4X4) begin : g_bad_entry_cfg
      $error("keypad_scan_ctrl: decimal entry needs a 4x4 matrix");
    end
    if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
      $error("keypad_scan_ctrl: DIGITS must be 1..6");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_t;

  logic [NUM_ROWS-1:0] sync1_q, rows_q;
  logic [DIV_W-1:0]    div_q;
  logic [CI_W-1:0]     ci_q;
  logic [NUM_COLS-1:0] col_q;
  logic                seen_q, multi_q;
  logic [IDX_W-1:0]    hit_q;
  state_t              state_q, state_d;
  logic [IDX_W-1:0]    cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                tick, eof, accept, release_done;
  logic [ROW_W-1:0]    row_pos;
  int                  row_ones;
  logic [IDX_W-1:0]    samp_idx, f_idx;
  logic                f_seen, f_multi, frame_none, frame_single;
  logic [IDX_W-1:0]    key_idx_q;
  logic [3:0]          key_legend_q, legend_d;
  logic                key_valid_q, key_held_q;
  logic [ACC_W-1:0]    acc_q, acc_d, entry_q, entry_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                ovf_q, ovf_d, entry_vld_q, entry_vld_d;

  function automatic logic [3:0] legend_of(input logic [IDX_W-1:0] idx);
    logic [3:0] r;
    r = '0;
    if (IS_4X4) begin
      for (int i = 0; i < 16; i++) begin
        if (int'(idx) == i) r = LEGEND_TBL[i*4 +: 4];
      end
    end
    return r;
  endfunction

  assign tick = (div_q == DIV_W'(SCAN_DIV - 1));
  assign eof  = tick && (ci_q == CI_W'(NUM_COLS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      rows_q  <= '0;
      div_q   <= '0;
      ci_q    <= '0;
      col_q   <= NUM_COLS'(1);
    end else begin
      sync1_q <= filas;
      rows_q  <= sync1_q;
      if (tick) begin
        div_q <= '0;
        col_q <= (col_q << 1) | (col_q >> (NUM_COLS - 1));
        ci_q  <= eof ? '0 : ci_q + CI_W'(1);
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  // Fold the current column's sample into the running frame summary.
  always_comb begin
    row_pos = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (rows_q[r]) row_pos = ROW_W'(r);
    end
    row_ones     = $countones(rows_q);
    samp_idx     = IDX_W'(int'(ci_q) * NUM_ROWS + int'(row_pos));
    f_seen       = seen_q || (row_ones != 0);
    f_multi      = multi_q || (row_ones > 1) || (seen_q && (row_ones != 0));
    f_idx        = seen_q ? hit_q : samp_idx;
    frame_none   = !f_seen;
    frame_single = f_seen && !f_multi;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen_q  <= 1'b0;
      multi_q <= 1'b0;
      hit_q   <= '0;
    end else if (tick) begin
      seen_q  <= eof ? 1'b0 : f_seen;
      multi_q <= eof ? 1'b0 : f_multi;
      hit_q   <= eof ? '0 : f_idx;
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    release_done = 1'b0;
    cnt_inc      = cnt_q + CNT_W'(1);
    if (eof) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_single) begin
            cand_d = f_idx;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_d = ST_HELD;
              cnt_d   = '0;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (frame_single && (f_idx == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
              accept  = 1'b1;
              state_d = ST_HELD;
              cnt_d   = '0;
            end
          end else if (frame_single) begin
            cand_d = f_idx;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          // A different key while held is ignored until a full release.
          if (frame_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              release_done = 1'b1;
              state_d      = ST_IDLE;
              cnt_d        = '0;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        default: begin
          if (frame_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
              release_done = 1'b1;
              state_d      = ST_IDLE;
              cnt_d        = '0;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    legend_d    = legend_of(f_idx);
    acc_d       = acc_q;
    dcnt_d      = dcnt_q;
    ovf_d       = ovf_q;
    entry_d     = entry_q;
    entry_vld_d = 1'b0;
    if (ENTRY_EN != 0 && accept) begin
      if (legend_d <= 4'd9) begin
        if (dcnt_q < DCNT_W'(DIGITS)) begin
          acc_d  = ACC_W'(int'(acc_q) * 10 + int'(legend_d));
          dcnt_d = dcnt_q + DCNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (legend_d == 4'hE) begin
        acc_d  = '0;
        dcnt_d = '0;
        ovf_d  = 1'b0;
      end else if (legend_d == 4'hF) begin
        entry_d     = acc_q;
        entry_vld_d = 1'b1;
        acc_d       = '0;
        dcnt_d      = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      key_idx_q    <= '0;
      key_legend_q <= '0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
      acc_q        <= '0;
      dcnt_q       <= '0;
      ovf_q        <= 1'b0;
      entry_q      <= '0;
      entry_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_valid_q <= accept;
      if (accept) begin
        key_idx_q    <= f_idx;
        key_legend_q <= legend_d;
        key_held_q   <= 1'b1;
      end else if (release_done) begin
        key_held_q <= 1'b0;
      end
      acc_q       <= acc_d;
      dcnt_q      <= dcnt_d;
      ovf_q       <= ovf_d;
      entry_q     <= entry_d;
      entry_vld_q <= entry_vld_d;
    end
  end

  assign col         = col_q;
  assign key_idx     = key_idx_q;
  assign key_legend  = key_legend_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign acc_value   = acc_q;
  assign digit_count = dcnt_q;
  assign overflow    = ovf_q;
  assign entry_value = entry_q;
  assign entry_valid = entry_vld_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a 4x4 keypad model driven frame by frame, checked against a
// frame-level reference model of debounce and decimal entry (SCAN_DIV=4, 3 debounce frames, 2 digits).
module tb_keypad_scan_ctrl;
  localparam int DS = 3;
  localparam int NDIG = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] filas;
  logic [3:0] col;
  logic [3:0] key_idx;
  logic [3:0] key_legend;
  logic       key_valid, key_held;
  logic [6:0] acc_value;
  logic [1:0] digit_count;
  logic       overflow;
  logic [6:0] entry_value;
  logic       entry_valid;

  logic [15:0] keys = '0;
  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_held;
  int m_hold_idx, m_run, m_run_idx, m_nrun;
  int m_kidx, m_leg, m_acc, m_dcnt, m_ovf, m_entry;
  bit exp_kv, exp_ev;

  keypad_scan_ctrl #(
    .NUM_COLS(4), .NUM_ROWS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(DS), .ENTRY_EN(1), .DIGITS(NDIG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .filas(filas), .col(col), .key_idx(key_idx),
    .key_legend(key_legend), .key_valid(key_valid), .key_held(key_held),
    .acc_value(acc_value), .digit_count(digit_count), .overflow(overflow),
    .entry_value(entry_value), .entry_valid(entry_valid)
  );

  always #5 clk = ~clk;

  // Pressed key (c,r) connects column c to row r.
  always_comb begin
    filas = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && col[c]) filas[r] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int legend_model(input int idx);
    int c, r;
    c = idx / 4;
    r = idx % 4;
    if (r == 3) return 10 + c;
    if (c < 3) return c * 3 + r + 1;
    if (r == 0) return 14;
    if (r == 1) return 0;
    return 15;
  endfunction

  task automatic model_reset();
    m_held = 0; m_hold_idx = 0; m_run = 0; m_run_idx = 0; m_nrun = 0;
    m_kidx = 0; m_leg = 0; m_acc = 0; m_dcnt = 0; m_ovf = 0; m_entry = 0;
    exp_kv = 0; exp_ev = 0;
  endtask

  task automatic model_accept(input int idx);
    m_kidx = idx;
    m_leg  = legend_model(idx);
    exp_kv = 1;
    if (m_leg <= 9) begin
      if (m_dcnt < NDIG) begin
        m_acc  = m_acc * 10 + m_leg;
        m_dcnt = m_dcnt + 1;
      end else m_ovf = 1;
    end else if (m_leg == 14) begin
      m_acc = 0; m_dcnt = 0; m_ovf = 0;
    end else if (m_leg == 15) begin
      m_entry = m_acc; exp_ev = 1; m_acc = 0; m_dcnt = 0;
    end
  endtask

  // One frame with a fixed key set: exactly-one-key frames build a run, release needs DS empty frames.
  task automatic model_frame(input logic [15:0] k);
    int n, idx;
    n = $countones(k);
    idx = 0;
    for (int i = 15; i >= 0; i--) if (k[i]) idx = i;
    exp_kv = 0;
    exp_ev = 0;
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && idx == m_run_idx) m_run++;
        else begin m_run = 1; m_run_idx = idx; end
        if (m_run == DS) begin
          model_accept(idx);
          m_held = 1; m_hold_idx = idx; m_run = 0; m_nrun = 0;
        end
      end else m_run = 0;
    end else begin
      if (n == 0) begin
        m_nrun++;
        if (m_nrun == DS) begin m_held = 0; m_run = 0; m_nrun = 0; end
      end else m_nrun = 0;
    end
  endtask

  // Starts at a frame-boundary negedge; 16 clocks per frame.
  task automatic run_frame(input logic [15:0] k);
    logic bad_col, bad_pulse;
    logic [3:0] exp_col;
    bad_col = 0;
    bad_pulse = 0;
    keys = k;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_col = 4'b0001 << ((i / 4) % 4);
      if (col !== exp_col) bad_col = 1;
      if (i < 16 && (key_valid !== 1'b0 || entry_valid !== 1'b0)) bad_pulse = 1;
    end
    chk("col_sequence", 32'(bad_col), 0);
    chk("no_midframe_pulse", 32'(bad_pulse), 0);
    model_frame(k);
    chk("key_valid", 32'(key_valid), 32'(exp_kv));
    chk("key_held", 32'(key_held), 32'(m_held));
    chk("key_idx", 32'(key_idx), 32'(m_kidx));
    chk("key_legend", 32'(key_legend), 32'(m_leg));
    chk("acc_value", 32'(acc_value), 32'(m_acc));
    chk("digit_count", 32'(digit_count), 32'(m_dcnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("entry_value", 32'(entry_value), 32'(m_entry));
    chk("entry_valid", 32'(entry_valid), 32'(exp_ev));
  endtask

  task automatic press(input int idx, input int n);
    for (int f = 0; f < n; f++) run_frame(16'(1) << idx);
  endtask

  task automatic idle(input int n);
    for (int f = 0; f < n; f++) run_frame('0);
  endtask

  task automatic reset_and_check();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_col", 32'(col), 1);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_key_held", 32'(key_held), 0);
    chk("rst_key_idx", 32'(key_idx), 0);
    chk("rst_legend", 32'(key_legend), 0);
    chk("rst_acc", 32'(acc_value), 0);
    chk("rst_digits", 32'(digit_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_entry", 32'(entry_value), 0);
    chk("rst_entry_valid", 32'(entry_valid), 0);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    keys = '0;
    reset_and_check();

    idle(3);

    // '8' is c2r1 -> index 9; accepted at the end of frame 3, never repeated.
    press(9, 3);
    chk("eight_idx", 32'(key_idx), 9);
    chk("eight_legend", 32'(key_legend), 8);
    chk("eight_held", 32'(key_held), 1);
    press(9, 2);
    idle(3);

    // '1' with a one-frame bounce gap.
    press(0, 1);
    idle(1);
    press(0, 2);
    chk("bounce_not_yet", 32'(key_held), 0);
    press(0, 1);
    chk("bounce_accepted", 32'(key_held), 1);
    idle(3);

    // Clear with '*', then 1,2,3 and '#'.
    press(12, 3); idle(3);
    press(0, 3);  idle(3);
    chk("acc_one", 32'(acc_value), 1);
    press(1, 3);  idle(3);
    chk("acc_twelve", 32'(acc_value), 12);
    press(2, 3);  idle(3);
    chk("acc_kept", 32'(acc_value), 12);
    chk("ovf_set", 32'(overflow), 1);
    press(14, 3);
    chk("enter_value", 32'(entry_value), 12);
    chk("enter_pulse", 32'(entry_valid), 1);
    chk("enter_acc_zero", 32'(acc_value), 0);
    idle(3);

    // '4' and '5' together, then '5' released.
    for (int f = 0; f < 3; f++) run_frame(16'h0030);
    chk("multi_no_hold", 32'(key_held), 0);
    press(4, 3);
    chk("four_idx", 32'(key_idx), 4);
    chk("four_legend", 32'(key_legend), 4);
    idle(3);

    // Reset while '7' is held; the key stays down and must be re-debounced.
    press(8, 4);
    reset_and_check();
    press(8, 2);
    chk("rehold_not_yet", 32'(key_held), 0);
    press(8, 1);
    chk("rehold_idx", 32'(key_idx), 8);
    chk("rehold_held", 32'(key_held), 1);
    idle(3);

    // Random key patterns in runs of whole frames.
    for (int seg = 0; seg < 80; seg++) begin
      int p, len, a, b;
      logic [15:0] k;
      p   = $urandom_range(0, 9);
      len = $urandom_range(1, 5);
      a   = $urandom_range(0, 15);
      b   = $urandom_range(0, 15);
      if (p < 4) k = '0;
      else if (p < 9) k = 16'(1) << a;
      else k = (16'(1) << a) | (16'(1) << b);
      for (int f = 0; f < len; f++) run_frame(k);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
